// File: rtl/writeback_queue.sv
// In-order write-back queue between the ALU/load producers and the register file write port.
// Also provides two forwarding lookups over the entries that are still queued.
module writeback_queue #(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    aluValid,
    output logic                    aluReady,
    input  logic [ADDR_WIDTH-1:0]   aluAddr,
    input  logic [BIT_WIDTH-1:0]    aluData,

    input  logic                    memValid,
    output logic                    memReady,
    input  logic [ADDR_WIDTH-1:0]   memAddr,
    input  logic [BIT_WIDTH-1:0]    memData,

    output logic                    writeEn,
    output logic [ADDR_WIDTH-1:0]   writeAddr,
    output logic [BIT_WIDTH-1:0]    writeData,

    input  logic [ADDR_WIDTH-1:0]   fwdAddr1,
    input  logic [ADDR_WIDTH-1:0]   fwdAddr2,
    output logic                    fwdHit1,
    output logic                    fwdHit2,
    output logic [BIT_WIDTH-1:0]    fwdData1,
    output logic [BIT_WIDTH-1:0]    fwdData2,

    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [BIT_WIDTH-1:0]  data_q [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW-1:0] alu_slot;
    logic [PtrW-1:0] scan_idx;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] free;

    logic mem_fire, alu_fire;
    logic mem_push, alu_push;
    logic pop;

    // The same-cycle pop gives no credit; loads win the last free slot.
    always_comb begin
        free     = DepthC - count_q;
        memReady = !rst && (free != '0);
        aluReady = !rst && ((free >= CntW'(2)) || ((free == CntW'(1)) && !memValid));
    end

    assign mem_fire = memValid && memReady;
    assign alu_fire = aluValid && aluReady;

    // x0 is never written, so its handshakes are swallowed without enqueueing.
    assign mem_push = mem_fire && (memAddr != '0);
    assign alu_push = alu_fire && (aluAddr != '0);

    assign writeEn   = !rst && (count_q != '0);
    assign writeAddr = addr_q[head_q];
    assign writeData = data_q[head_q];
    assign pop       = writeEn;

    // The load entry is older, so the ALU entry lands one slot behind it.
    assign alu_slot = tail_q + PtrW'(mem_push);

    always_comb begin
        head_d  = head_q + PtrW'(pop);
        tail_d  = tail_q + PtrW'(mem_push) + PtrW'(alu_push);
        count_d = count_q + CntW'(mem_push) + CntW'(alu_push) - CntW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            addr_q[tail_q] <= memAddr;
            data_q[tail_q] <= memData;
        end
        if (alu_push) begin
            addr_q[alu_slot] <= aluAddr;
            data_q[alu_slot] <= aluData;
        end
    end

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwdHit1  = 1'b0;
        fwdHit2  = 1'b0;
        fwdData1 = '0;
        fwdData2 = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                if ((fwdAddr1 != '0) && (addr_q[scan_idx] == fwdAddr1)) begin
                    fwdHit1  = 1'b1;
                    fwdData1 = data_q[scan_idx];
                end
                if ((fwdAddr2 != '0) && (addr_q[scan_idx] == fwdAddr2)) begin
                    fwdHit2  = 1'b1;
                    fwdData2 = data_q[scan_idx];
                end
            end
        end
    end

    assign count = count_q;
    assign full  = (count_q == DepthC);
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vectors with literal checks, plus a queue-based model
// compared against every DUT output once per cycle.
module tb_writeback_queue;

    localparam int BW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          aluValid, aluReady, memValid, memReady;
    logic [AW-1:0] aluAddr, memAddr, writeAddr, fwdAddr1, fwdAddr2;
    logic [BW-1:0] aluData, memData, writeData, fwdData1, fwdData2;
    logic          writeEn, fwdHit1, fwdHit2, full, empty;
    logic [CW-1:0] count;

    writeback_queue #(
        .BIT_WIDTH  (BW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aluValid  (aluValid),
        .aluReady  (aluReady),
        .aluAddr   (aluAddr),
        .aluData   (aluData),
        .memValid  (memValid),
        .memReady  (memReady),
        .memAddr   (memAddr),
        .memData   (memData),
        .writeEn   (writeEn),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .fwdAddr1  (fwdAddr1),
        .fwdAddr2  (fwdAddr2),
        .fwdHit1   (fwdHit1),
        .fwdHit2   (fwdHit2),
        .fwdData1  (fwdData1),
        .fwdData2  (fwdData2),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register file image built from what the DUT actually writes.
    logic [BW-1:0] rf [32];
    always @(posedge clk) begin
        if (writeEn === 1'b1) rf[writeAddr] <= writeData;
    end

    // Model: an ordered list of pending {addr,data}, updated once per edge.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   started = 0;
    int   m_free;
    bit   m_macc, m_aacc;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            started = 1;
        end else if (started) begin
            m_free = DEPTH - mq.size();
            m_macc = memValid && (m_free >= 1);
            m_aacc = aluValid && ((m_free >= 2) || (m_free == 1 && !memValid));
            if (mq.size() > 0) void'(mq.pop_front());
            if (m_macc && memAddr != 0) mq.push_back('{a: memAddr, d: memData});
            if (m_aacc && aluAddr != 0) mq.push_back('{a: aluAddr, d: aluData});
        end
    end

    int            e_free;
    bit            e_mr, e_ar, e_we, e_h1, e_h2;
    logic [BW-1:0] e_d1, e_d2;

    always @(negedge clk) begin
        if (started) begin
            e_free = DEPTH - mq.size();
            e_mr   = !rst && (e_free >= 1);
            e_ar   = !rst && ((e_free >= 2) || (e_free == 1 && !memValid));
            e_we   = !rst && (mq.size() > 0);
            e_h1 = 0; e_h2 = 0; e_d1 = '0; e_d2 = '0;
            for (int i = 0; i < mq.size(); i++) begin
                if (fwdAddr1 != 0 && mq[i].a == fwdAddr1) begin e_h1 = 1; e_d1 = mq[i].d; end
                if (fwdAddr2 != 0 && mq[i].a == fwdAddr2) begin e_h2 = 1; e_d2 = mq[i].d; end
            end
            chk("cmp_memReady", memReady, e_mr);
            chk("cmp_aluReady", aluReady, e_ar);
            chk("cmp_writeEn", writeEn, e_we);
            if (e_we) begin
                chk("cmp_writeAddr", writeAddr, mq[0].a);
                chk("cmp_writeData", writeData, mq[0].d);
            end
            chk("cmp_count", count, mq.size());
            chk("cmp_full", full, mq.size() == DEPTH);
            chk("cmp_empty", empty, mq.size() == 0);
            chk("cmp_fwdHit1", fwdHit1, e_h1);
            chk("cmp_fwdData1", fwdData1, e_d1);
            chk("cmp_fwdHit2", fwdHit2, e_h2);
            chk("cmp_fwdData2", fwdData2, e_d2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        aluValid = 0; aluAddr = '0; aluData = '0;
        memValid = 0; memAddr = '0; memData = '0;
    endtask

    task automatic drive(input bit av, input int aa, input logic [BW-1:0] ad,
                         input bit mv, input int ma, input logic [BW-1:0] md);
        aluValid = av; aluAddr = AW'(aa); aluData = ad;
        memValid = mv; memAddr = AW'(ma); memData = md;
    endtask

    initial begin
        idle();
        fwdAddr1 = '0;
        fwdAddr2 = '0;
        rst = 1;
        tick();
        tick();
        chk("rst_aluReady", aluReady, 0);
        chk("rst_memReady", memReady, 0);
        chk("rst_writeEn", writeEn, 0);
        rst = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);

        // Single load, written the cycle after acceptance.
        drive(0, 0, 0, 1, 3, 32'hAAAA0001);
        #1;
        chk("t1_memReady", memReady, 1);
        tick(); idle(); #1;
        chk("t1_writeEn", writeEn, 1);
        chk("t1_writeAddr", writeAddr, 3);
        chk("t1_writeData", writeData, 32'hAAAA0001);
        tick(); #1;
        chk("t1_writeEn_off", writeEn, 0);
        chk("t1_empty", empty, 1);

        // Same-register ALU and load together: load drains first, ALU wins.
        drive(1, 5, 32'h11, 1, 5, 32'h22);
        #1;
        chk("t2_aluReady", aluReady, 1);
        chk("t2_memReady", memReady, 1);
        tick(); idle(); fwdAddr1 = 5; fwdAddr2 = 9; #1;
        chk("t2_count", count, 2);
        chk("t2_first_data", writeData, 32'h22);
        chk("t2_fwdHit1", fwdHit1, 1);
        chk("t2_fwdData1", fwdData1, 32'h11);
        chk("t2_fwdHit2", fwdHit2, 0);
        tick(); #1;
        chk("t2_second_data", writeData, 32'h11);
        chk("t2_fwdData1_b", fwdData1, 32'h11);
        tick(); #1;
        chk("t2_empty", empty, 1);
        chk("t2_rf5", rf[5], 32'h11);
        fwdAddr1 = 0; fwdAddr2 = 0;

        // Build up to three entries, then one free slot goes to the load.
        drive(1, 6, 32'h61, 1, 7, 32'h71);
        tick();
        drive(1, 8, 32'h81, 1, 9, 32'h91);
        #1;
        chk("t3_count2", count, 2);
        chk("t3_aluReady_f2", aluReady, 1);
        tick();
        drive(1, 10, 32'hA1, 1, 11, 32'hB1);
        #1;
        chk("t3_count3", count, 3);
        chk("t3_memReady", memReady, 1);
        chk("t3_aluReady", aluReady, 0);
        fwdAddr2 = 9;
        #1;
        chk("t3_fwdData2", fwdData2, 32'h91);
        tick(); idle(); fwdAddr2 = 11; #1;
        chk("t3_count_hold", count, 3);
        chk("t3_fwdHit2_b1", fwdHit2, 1);
        chk("t3_fwdData2_b1", fwdData2, 32'hB1);
        fwdAddr2 = 10;
        #1;
        chk("t3_alu10_dropped", fwdHit2, 0);
        fwdAddr2 = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_drained", empty, 1);
        chk("t3_rf11", rf[11], 32'hB1);

        // Address 0 handshake: accepted, never queued or forwarded.
        drive(1, 0, 32'hFFFF, 0, 0, 0);
        fwdAddr1 = 0;
        #1;
        chk("t4_aluReady", aluReady, 1);
        chk("t4_fwdHit1", fwdHit1, 0);
        tick(); idle(); #1;
        chk("t4_count", count, 0);
        chk("t4_writeEn", writeEn, 0);

        // Reset mid-drain discards everything.
        drive(1, 12, 32'hC1, 1, 13, 32'hD1);
        tick();
        drive(1, 14, 32'hE1, 1, 15, 32'hF1);
        tick(); idle(); #1;
        chk("t5_count3", count, 3);
        rst = 1;
        #1;
        chk("t5_rst_writeEn", writeEn, 0);
        chk("t5_rst_memReady", memReady, 0);
        tick();
        rst = 0;
        #1;
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5_no_write_%0d", i), writeEn, 0);
            tick();
        end

        // One ALU result per cycle: queue never holds more than one entry.
        for (int i = 1; i <= 8; i++) begin
            drive(1, i, 32'h100 + i, 0, 0, 0);
            #1;
            chk($sformatf("t6_aluReady_%0d", i), aluReady, 1);
            if (i > 1) begin
                chk($sformatf("t6_count_%0d", i), count, 1);
                chk($sformatf("t6_waddr_%0d", i), writeAddr, i - 1);
                chk($sformatf("t6_wdata_%0d", i), writeData, 32'h100 + i - 1);
            end
            tick();
        end
        idle(); #1;
        chk("t6_waddr_last", writeAddr, 8);
        chk("t6_wdata_last", writeData, 32'h108);
        tick(); #1;
        chk("t6_empty", empty, 1);
        chk("t6_rf8", rf[8], 32'h108);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
